// File: rtl/holo_pkg.sv
// Shared LSU definitions: funct3 codes, opcodes, state enum.
// Helpers classify funct3 legality and transfer length.
package holo_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    CAPT,
    RESP
  } lsu_state_e;

  function automatic logic f3_legal(
    input logic       store,
    input logic [2:0] f3
  );
    logic ok;
    if (store)
      ok = (f3 == F3_SB) || (f3 == F3_SH) ||
           (f3 == F3_SW);
    else
      ok = (f3 == F3_LB) || (f3 == F3_LH) ||
           (f3 == F3_LW) || (f3 == F3_LBU) ||
           (f3 == F3_LHU);
    return ok;
  endfunction

  // Index of the final byte: 0 for B, 1 for H, 3 for W.
  function automatic logic [1:0] f3_last(
    input logic [2:0] f3
  );
    logic [1:0] l;
    case (f3[1:0])
      2'b00:   l = 2'd0;
      2'b01:   l = 2'd1;
      default: l = 2'd3;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/holo_lsu_if.sv
// Core request/response and byte-wide data-memory bundle.
// master = core + memory side, slave = LSU.
interface holo_lsu_if #(
  parameter int AW = 32
);

  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [2:0]    req_f3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;

  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_oe;
  logic          mem_we;
  logic [7:0]    mem_rdata;

  modport master (
    output req_valid, req_store, req_f3,
    output req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, mem_addr, mem_wdata,
    input  mem_oe, mem_we
  );

  modport slave (
    input  req_valid, req_store, req_f3,
    input  req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, mem_addr, mem_wdata,
    output mem_oe, mem_we
  );

endinterface

// File: rtl/holo_load_ext.sv
// Load result extension: raw little-endian word + funct3
// to the architectural register value.
module holo_load_ext
  import holo_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [2:0]  f3_i,
  output logic [31:0] res_o
);

  always_comb begin
    res_o = raw_i;
    unique case (1'b1)
      f3_i == F3_LB:
        res_o = {{24{raw_i[7]}}, raw_i[7:0]};
      f3_i == F3_LH:
        res_o = {{16{raw_i[15]}}, raw_i[15:0]};
      f3_i == F3_LBU:
        res_o = {24'h0, raw_i[7:0]};
      f3_i == F3_LHU:
        res_o = {16'h0, raw_i[15:0]};
      default:
        res_o = raw_i;
    endcase
  end

endmodule

// File: rtl/holo_lsu.sv
// Byte-serial RV32I load/store unit over an 8-bit memory.
// One byte per XFER; loads spend a CAPT cycle per byte.
module holo_lsu
  import holo_pkg::*;
#(
  parameter int AW = 32
) (
  input logic      clk,
  input logic      rst,
  holo_lsu_if.slave bus
);

  lsu_state_e    state_q;
  logic          store_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] base_q;
  logic [31:0]   wdata_q;
  logic [1:0]    k_q;
  logic [1:0]    last_q;
  logic [31:0]   raw_q;

  logic [AW-1:0] mem_addr_q;
  logic [7:0]    mem_wdata_q;
  logic          mem_oe_q;
  logic          mem_we_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q;

  logic [1:0]    k_inc;
  logic [AW-1:0] addr_inc;
  logic [7:0]    wbyte_inc;
  logic [31:0]   raw_d;
  logic [31:0]   ext_res;
  logic          acc_ok;

  assign k_inc     = k_q + 2'd1;
  assign addr_inc  = base_q + AW'(k_inc);
  assign wbyte_inc = wdata_q[{k_inc, 3'b000} +: 8];
  assign acc_ok    = f3_legal(bus.req_store,
                              bus.req_f3);

  // Raw word with the byte arriving this cycle merged in.
  always_comb begin
    raw_d = raw_q;
    raw_d[{k_q, 3'b000} +: 8] = bus.mem_rdata;
  end

  holo_load_ext u_ext (
    .raw_i (raw_d),
    .f3_i  (f3_q),
    .res_o (ext_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      f3_q         <= 3'b000;
      base_q       <= '0;
      wdata_q      <= 32'h0;
      k_q          <= 2'd0;
      last_q       <= 2'd0;
      raw_q        <= 32'h0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'h0;
      mem_oe_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      mem_oe_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (bus.req_valid) begin
          store_q      <= bus.req_store;
          f3_q         <= bus.req_f3;
          base_q       <= bus.req_addr;
          wdata_q      <= bus.req_wdata;
          k_q          <= 2'd0;
          last_q       <= f3_last(bus.req_f3);
          raw_q        <= 32'h0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
          if (!acc_ok) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            state_q    <= XFER;
            mem_addr_q <= bus.req_addr;
            if (bus.req_store) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= bus.req_wdata[7:0];
            end else begin
              mem_oe_q    <= 1'b1;
            end
          end
        end
        XFER: if (!store_q) begin
          state_q <= CAPT;
        end else if (k_q == last_q) begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end else begin
          k_q         <= k_inc;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= addr_inc;
          mem_wdata_q <= wbyte_inc;
        end
        CAPT: begin
          raw_q <= raw_d;
          if (k_q == last_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ext_res;
          end else begin
            state_q    <= XFER;
            k_q        <= k_inc;
            mem_oe_q   <= 1'b1;
            mem_addr_q <= addr_inc;
          end
        end
        RESP: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_oe     = mem_oe_q;
  assign bus.mem_we     = mem_we_q;

endmodule

// File: doc/holo_lsu.md
HOLO_LSU -- requirements
Module: holo_lsu

Interface
REQ-001 SHALL have parameter AW, default 32, meaning data-bus address width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  core presents a load/store request.
REQ-005 SHALL have port req_ready  output  1  LSU accepts a request this cycle.
REQ-006 SHALL have port req_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_f3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW).
REQ-008 SHALL have port req_addr  input  AW  effective byte address (rs1 + imm).
REQ-009 SHALL have port req_wdata  input  32  store data (rs2).
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1  illegal funct3; valid only with resp_valid.
REQ-013 SHALL have port mem_addr  output  AW  data-memory byte address.
REQ-014 SHALL have port mem_wdata  output  8  data-memory write byte.
REQ-015 SHALL have port mem_oe  output  1  data-memory read enable.
REQ-016 SHALL have port mem_we  output  1  data-memory write enable.
REQ-017 SHALL have port mem_rdata  input  8  data-memory read byte, valid the cycle after mem_oe.

Function
REQ-018 SHALL use states IDLE, XFER, CAPT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 SHALL accept a request on a clk edge with req_valid=1 in IDLE, latch addr/wdata/f3/store, set byte count N (1 for B/BU, 2 for H/HU, 4 for W), set index k=0, and go to XFER.
REQ-020 SHALL ignore req_valid outside IDLE.
REQ-021 In XFER: mem_addr = base+k mod 2^AW. Load: mem_oe=1, next state CAPT. Store: mem_we=1, mem_wdata=wdata byte k (little-endian); then k+1, and RESP once k=N-1.
REQ-022 In CAPT: mem_rdata SHALL be written to result byte lane k; then k+1, and return to XFER, or go to RESP once k=N-1.
REQ-023 Latency from accept edge to resp_valid: load 2N+1 cycles (LW 9, LH 5, LB 3); store N+1 cycles (SW 5, SH 3, SB 2).
REQ-024 In RESP, resp_valid SHALL be 1 for exactly one cycle, then return to IDLE.
REQ-025 Load extension: LB sign-extends bit 7; LH sign-extends bit 15; LBU/LHU zero-extend; LW passes 32 bits unchanged.
REQ-026 Illegal funct3 (load 3/6/7, store 3-7): no mem_oe/mem_we; go directly to RESP with resp_err=1 and resp_rdata=0 (latency 1).
REQ-027 SHALL NOT check alignment; misaligned accesses are byte-serial like aligned ones.
REQ-028 Address increment SHALL wrap modulo 2^AW (0xFFFFFFFF+1 = 0x0).
REQ-029 mem_oe and mem_we SHALL never both be 1, and SHALL be 0 in IDLE and RESP.
REQ-030 mem_addr and mem_wdata SHALL hold their last driven values when no enable is active.

Reset
REQ-031 While rst=1: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_oe=0, mem_we=0, mem_addr=0, mem_wdata=0, k=0, taking effect immediately, with no clock edge.
REQ-032 Reset mid-access SHALL abandon the transfer with no resp_valid; the first request after rst deasserts SHALL behave as from power-up.

Structure
REQ-033 SHALL import shared package holo_pkg, which holds the LB/LH/LW/LBU/LHU and SB/SH/SW funct3 constants, the LOAD/STORE opcodes, and the LSU state enum.
REQ-034 SHALL instantiate one combinational sub-module holo_load_ext (raw 32-bit word + funct3 -> extended result); all sequencing stays in holo_lsu.

Verification
REQ-035 LW at addr 0x10, memory bytes 0x78,0x56,0x34,0x12 -> mem_oe addrs 0x10..0x13, resp_rdata=0x12345678 with resp_valid 9 cycles after accept.
REQ-036 LB at 0x20 = 0x80 -> 0xFFFFFF80; LBU at same -> 0x00000080; LH at 0x20 = {0x80,0xFF} -> 0xFFFFFF80.
REQ-037 SW 0xDEADBEEF at 0x3 -> writes 0xEF@3, 0xBE@4, 0xAD@5, 0xDE@6, one mem_we cycle each; resp_valid 5 cycles after accept, resp_rdata=0.
REQ-038 SH at 0xFFFFFFFF, wdata 0xAABB -> 0xBB@0xFFFFFFFF, 0xAA@0x0.
REQ-039 Load with f3=3 and store with f3=4 -> resp_err=1 one cycle after accept, no mem_oe/mem_we.
REQ-040 Assert rst during the 3rd byte of an LW -> enables drop immediately, no resp_valid; a following LB completes correctly; req_valid pulsed during busy is ignored.
